blur_frame_ctrl: RTL and testbench

- Frame-level sequencer between the pixel stream source, the blur accelerator core and the result sink.
- On a start pulse it opens the input stream for exactly IMG_W*IMG_H pixels and generates the authoritative last marker.
- It passes OUT_W*OUT_H result pixels to the sink, then signals done and returns to idle.
- It flags upstream last-marker mismatches as sticky errors and counts completed frames.

---
 rtl/blur_ctrl_pkg.sv | 25 ++
 rtl/frame_pos_cnt.sv | 47 ++++
 rtl/blur_frame_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_blur_frame_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blur_ctrl_pkg.sv
// Shared definitions for the blur frame sequencer.
//   state_t      : frame sequencer states
//   DEF_*        : default data width and frame dimensions
//   cnt_width()  : bit width of a position counter for a given dimension
package blur_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_DW    = 8;
    localparam int DEF_IMG_W = 260;
    localparam int DEF_IMG_H = 258;
    localparam int DEF_OUT_W = 258;
    localparam int DEF_OUT_H = 256;

    // A dimension of 1 still needs a one-bit counter so the vectors stay legal.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_pos_cnt.sv
// Column/row position counter for a W x H raster.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : synchronous return to column 0 / row 0 (wins over inc)
//   inc        : advance one pixel; column wraps at W-1 and bumps the row
//   is_last    : current position is the final pixel of the frame
module frame_pos_cnt
    import blur_ctrl_pkg::*;
#(
    parameter int W = DEF_IMG_W,
    parameter int H = DEF_IMG_H
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic is_last
);

    localparam int CW = cnt_width(W);
    localparam int RW = cnt_width(H);
    localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (clr) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (inc) begin
            if (col_reg == COL_MAX) begin
                col_reg <= '0;
                // Row also wraps so the counter never leaves the frame.
                row_reg <= (row_reg == ROW_MAX) ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    assign is_last = (col_reg == COL_MAX) && (row_reg == ROW_MAX);

endmodule

// File: rtl/blur_frame_ctrl.sv
// Frame-level sequencer between a pixel source, the blur accelerator and a
// result sink.
//   clk, reset        : clock, asynchronous active-low reset
//   start_in          : frame start request (ignored while busy)
//   busy, done        : frame in progress / one-cycle completion pulse
//   in_*              : source stream (in_last is only checked)
//   acc_*             : stream to the accelerator, acc_last generated here
//   res_*             : result stream from the accelerator
//   out_*             : stream to the sink, out_last generated here
//   err_last_early    : sticky, source marked last on a non-final pixel
//   err_last_missing  : sticky, source did not mark the final pixel
//   frame_cnt         : completed frames, wraps at 2^16
module blur_frame_ctrl
    import blur_ctrl_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int OUT_W = DEF_OUT_W,
    parameter int OUT_H = DEF_OUT_H
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_in,
    output logic          busy,
    output logic          done,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [DW-1:0] acc_data,
    output logic          acc_valid,
    output logic          acc_last,
    input  logic          acc_ready,
    input  logic [DW-1:0] res_data,
    input  logic          res_valid,
    output logic          res_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          err_last_early,
    output logic          err_last_missing,
    output logic [15:0]   frame_cnt
);

    state_t state_reg, state_next;

    logic        in_done_reg;
    logic        out_done_reg;
    logic        err_early_reg;
    logic        err_missing_reg;
    logic [15:0] frame_cnt_reg;

    logic gate_in, gate_out;
    logic in_xfer, out_xfer;
    logic in_is_last, out_is_last;
    logic in_final, out_final;
    logic in_done_eff, out_done_eff;
    logic start_accept;

    assign start_accept = (state_reg == ST_IDLE) && start_in;

    // Input path: straight wires, gated only by state and the in_done flag,
    // so in_ready never depends on in_valid.
    assign gate_in   = (state_reg == ST_RUN) && !in_done_reg;
    assign acc_valid = in_valid && gate_in;
    assign in_ready  = acc_ready && gate_in;
    assign acc_data  = in_data;
    assign in_xfer   = in_valid && in_ready;
    assign acc_last  = gate_in && in_is_last;
    assign in_final  = in_xfer && in_is_last;

    // Output path: open in RUN and FLUSH until the final result has passed.
    assign gate_out  = ((state_reg == ST_RUN) || (state_reg == ST_FLUSH)) && !out_done_reg;
    assign out_valid = res_valid && gate_out;
    assign res_ready = out_ready && gate_out;
    assign out_data  = res_data;
    assign out_xfer  = out_valid && out_ready;
    assign out_last  = gate_out && out_is_last;
    assign out_final = out_xfer && out_is_last;

    // Include this cycle's final transfers so the state moves on the same
    // edge that completes a stream (done follows the last pixel by one cycle).
    assign in_done_eff  = in_done_reg || in_final;
    assign out_done_eff = out_done_reg || out_final;

    frame_pos_cnt #(
        .W (IMG_W),
        .H (IMG_H)
    ) u_in_pos (
        .clk     (clk),
        .reset   (reset),
        .clr     (start_accept),
        .inc     (in_xfer),
        .is_last (in_is_last)
    );

    frame_pos_cnt #(
        .W (OUT_W),
        .H (OUT_H)
    ) u_out_pos (
        .clk     (clk),
        .reset   (reset),
        .clr     (start_accept),
        .inc     (out_xfer),
        .is_last (out_is_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start_in) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                // If the output side finishes first we simply stay here with
                // res_ready held low until the input side catches up.
                if (in_done_eff && out_done_eff) begin
                    state_next = ST_DONE;
                end else if (in_done_eff) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if (out_done_eff) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_done_reg     <= 1'b0;
            out_done_reg    <= 1'b0;
            err_early_reg   <= 1'b0;
            err_missing_reg <= 1'b0;
            frame_cnt_reg   <= '0;
        end else begin
            if (start_accept) begin
                in_done_reg  <= 1'b0;
                out_done_reg <= 1'b0;
            end else begin
                if (in_final) begin
                    in_done_reg <= 1'b1;
                end
                if (out_final) begin
                    out_done_reg <= 1'b1;
                end
            end
            // Error flags survive start; only reset clears them.
            if (in_xfer && in_last && !acc_last) begin
                err_early_reg <= 1'b1;
            end
            if (in_xfer && acc_last && !in_last) begin
                err_missing_reg <= 1'b1;
            end
            if (state_reg == ST_DONE) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
        end
    end

    assign err_last_early   = err_early_reg;
    assign err_last_missing = err_missing_reg;
    assign frame_cnt        = frame_cnt_reg;

endmodule

// File: tb/tb_blur_frame_ctrl.sv
// Scoreboard bench for blur_frame_ctrl using a reduced frame size.
module tb_blur_frame_ctrl;

    localparam int DW    = 8;
    localparam int IMG_W = 7;
    localparam int IMG_H = 5;
    localparam int OUT_W = 5;
    localparam int OUT_H = 3;
    localparam int N_IN  = IMG_W * IMG_H;
    localparam int N_OUT = OUT_W * OUT_H;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_in;
    logic          busy, done;
    logic [DW-1:0] in_data;
    logic          in_valid, in_last, in_ready;
    logic [DW-1:0] acc_data;
    logic          acc_valid, acc_last, acc_ready;
    logic [DW-1:0] res_data;
    logic          res_valid, res_ready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_last, out_ready;
    logic          err_last_early, err_last_missing;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    blur_frame_ctrl #(
        .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_W(OUT_W), .OUT_H(OUT_H)
    ) dut (
        .clk(clk), .reset(reset), .start_in(start_in), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .acc_data(acc_data), .acc_valid(acc_valid), .acc_last(acc_last), .acc_ready(acc_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .err_last_early(err_last_early), .err_last_missing(err_last_missing),
        .frame_cnt(frame_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    int checks = 0;
    int failures = 0;
    bit stall_mode = 1'b0;
    bit abort_src = 1'b0;

    beat_t         exp_acc[$];
    beat_t         exp_out[$];
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] acc_buf[$];
    int            res_idx = 0;
    int            acc_xfers = 0;
    int            out_xfers = 0;
    int            done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference 3x3 box blur (sum/9, truncated) of a raster-ordered frame.
    function automatic logic [DW-1:0] blur_at(input logic [DW-1:0] img[$], input int k);
        int r, c, s;
        r = k / OUT_W;
        c = k % OUT_W;
        s = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                s += int'(img[(r + dr) * IMG_W + c + dc]);
        return DW'(s / 9);
    endfunction

    // Result k can only exist once its whole 3x3 window has been received.
    function automatic int need_in(input int k);
        return (k / OUT_W + 2) * IMG_W + (k % OUT_W) + 3;
    endfunction

    task automatic make_frame();
        logic [DW-1:0] img[$];
        logic [DW-1:0] p;
        beat_t b;
        for (int i = 0; i < N_IN; i++) begin
            p = DW'($urandom);
            img.push_back(p);
            src_q.push_back(p);
            b.data = p;
            b.last = (i == N_IN - 1);
            exp_acc.push_back(b);
        end
        for (int k = 0; k < N_OUT; k++) begin
            b.data = blur_at(img, k);
            b.last = (k == N_OUT - 1);
            exp_out.push_back(b);
        end
    endtask

    task automatic send_pixels(input int n, input int early_idx, input bit no_final_last);
        int idx;
        for (int i = 0; i < n; i++) begin
            if (abort_src) break;
            if (stall_mode && ($urandom % 2 == 1)) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #1;
            end
            idx = i % N_IN;
            in_data  = src_q.pop_front();
            in_last  = (idx == N_IN - 1) ? !no_final_last : (idx == early_idx);
            in_valid = 1'b1;
            @(negedge clk);
            while (!in_ready && !abort_src) @(negedge clk);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
    endtask

    task automatic check_frame(input string tag, input int a0, input int o0, input int d0,
                               input int f0, input int nfr, input bit e_early, input bit e_miss);
        check({tag, "_in_count"}, 32'(acc_xfers - a0), 32'(N_IN * nfr));
        check({tag, "_out_count"}, 32'(out_xfers - o0), 32'(N_OUT * nfr));
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'(nfr));
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'((f0 + nfr) % 65536));
        check({tag, "_busy_after"}, 32'(busy), 32'(0));
        check({tag, "_acc_left"}, 32'(exp_acc.size()), 32'(0));
        check({tag, "_out_left"}, 32'(exp_out.size()), 32'(0));
        check({tag, "_err_early"}, 32'(err_last_early), 32'(e_early));
        check({tag, "_err_missing"}, 32'(err_last_missing), 32'(e_miss));
        $display("frame %s: in=%0d out=%0d done=%0d frame_cnt=%0d", tag,
                 acc_xfers - a0, out_xfers - o0, done_cnt - d0, frame_cnt);
    endtask

    task automatic run_frame(input string tag, input int early_idx, input bit no_final_last,
                             input bit mid_start, input bit e_early, input bit e_miss);
        int a0, o0, d0, f0;
        a0 = acc_xfers; o0 = out_xfers; d0 = done_cnt; f0 = int'(frame_cnt);
        make_frame();
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        fork
            send_pixels(N_IN, early_idx, no_final_last);
            if (mid_start) begin
                repeat (N_IN / 2) @(posedge clk);
                #1 start_in = 1'b1;
                @(posedge clk);
                #1 start_in = 1'b0;
            end
        join
        wait_done(d0 + 1);
        repeat (4) @(posedge clk);
        #1;
        check_frame(tag, a0, o0, d0, f0, 1, e_early, e_miss);
    endtask

    // Accelerator and sink model: buffers what it receives and emits blurred
    // results once each window is complete.
    initial begin
        bit ax, rx;
        acc_ready = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            ax = acc_valid && acc_ready;
            rx = res_valid && res_ready;
            if (ax) acc_buf.push_back(acc_data);
            @(posedge clk);
            #1;
            if (rx) begin
                res_idx++;
                res_valid = 1'b0;
            end
            if (res_idx == N_OUT) begin
                res_idx = 0;
                acc_buf.delete();
            end
            acc_ready = stall_mode ? 1'($urandom % 2) : 1'b1;
            out_ready = stall_mode ? 1'($urandom % 2) : 1'b1;
            if (!res_valid && res_idx < N_OUT && acc_buf.size() >= need_in(res_idx)
                && (!stall_mode || ($urandom % 2 == 1))) begin
                res_valid = 1'b1;
                res_data  = blur_at(acc_buf, res_idx);
            end
        end
    end

    // Monitor: pops the scoreboard queues on every handshake.
    initial begin
        beat_t b;
        bit prev_out_final = 1'b0;
        bit prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (acc_valid && acc_ready) begin
                    acc_xfers++;
                    if (exp_acc.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL acc_unexpected actual=%0d required=none", acc_data);
                    end else begin
                        b = exp_acc.pop_front();
                        check("acc_data", 32'(acc_data), 32'(b.data));
                        check("acc_last", 32'(acc_last), 32'(b.last));
                    end
                end
                if (out_valid && out_ready) begin
                    out_xfers++;
                    if (exp_out.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL out_unexpected actual=%0d required=none", out_data);
                    end else begin
                        b = exp_out.pop_front();
                        check("out_data", 32'(out_data), 32'(b.data));
                        check("out_last", 32'(out_last), 32'(b.last));
                    end
                end
                if (done || prev_out_final) check("done_after_last", 32'(done), 32'(prev_out_final));
                if (prev_done) check("idle_in_ready", 32'(in_ready), 32'(0));
                if (done) done_cnt++;
                prev_out_final = out_valid && out_ready && out_last;
                prev_done = done;
            end else begin
                prev_out_final = 1'b0;
                prev_done = 1'b0;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int a0, o0, d0, f0, t;
        reset    = 1'b0;
        start_in = 1'b0;
        in_valid = 1'b1;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_acc_valid", 32'(acc_valid), 32'(0));
        check("rst_res_ready", 32'(res_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_acc_last", 32'(acc_last), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        stall_mode = 1'b0;
        run_frame("nostall", -1, 1'b0, 1'b0, 1'b0, 1'b0);
        stall_mode = 1'b1;
        run_frame("stall", -1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("midstart", -1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame("lasterr", 10, 1'b1, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of a frame.
        stall_mode = 1'b0;
        a0 = acc_xfers;
        make_frame();
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        fork
            send_pixels(N_IN, -1, 1'b0);
            begin
                t = 0;
                while (acc_xfers < a0 + 20 && t < 1000) begin
                    @(posedge clk);
                    t++;
                end
                #3 reset = 1'b0;
                #1;
                check("mid_rst_busy", 32'(busy), 32'(0));
                check("mid_rst_in_ready", 32'(in_ready), 32'(0));
                check("mid_rst_acc_valid", 32'(acc_valid), 32'(0));
                check("mid_rst_res_ready", 32'(res_ready), 32'(0));
                check("mid_rst_err_early", 32'(err_last_early), 32'(0));
                check("mid_rst_err_missing", 32'(err_last_missing), 32'(0));
                check("mid_rst_frame_cnt", 32'(frame_cnt), 32'(0));
                $display("reset asserted after %0d input pixels", acc_xfers - a0);
                abort_src = 1'b1;
            end
        join
        repeat (2) @(negedge clk);
        exp_acc.delete();
        exp_out.delete();
        src_q.delete();
        acc_buf.delete();
        res_idx = 0;
        res_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        abort_src = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_frame("after_rst", -1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back frames with start held high.
        stall_mode = 1'b1;
        a0 = acc_xfers; o0 = out_xfers; d0 = done_cnt; f0 = int'(frame_cnt);
        make_frame();
        make_frame();
        start_in = 1'b1;
        @(posedge clk);
        #1;
        send_pixels(2 * N_IN, -1, 1'b0);
        start_in = 1'b0;
        wait_done(d0 + 2);
        repeat (4) @(posedge clk);
        #1;
        check_frame("b2b", a0, o0, d0, f0, 2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
